// File: rtl/iter_comparator.sv
// iter_comparator: multi-cycle chunked magnitude/equality compare, MSB chunk first.
// Define ITER_COMPARATOR_EARLY_EXIT_EN to stop on the first differing chunk.
module iter_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             isEqual,
  output logic             isLessThan,
  output logic             isGreaterThan
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] TOP = CW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

`ifdef ITER_COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic             fixed_q;
  logic             gt_q;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic             fixed_n;
  logic             gt_n;
  logic             done;

  assign busy = (state == RUN);

  // Pick the current chunk, bias the top chunk's sign bit, fold into the decision
  always_comb begin
    a_c = a_q[int'(cnt)*CHUNK +: CHUNK];
    b_c = b_q[int'(cnt)*CHUNK +: CHUNK];
    if (sgn_q && cnt == TOP) begin
      a_c = a_c ^ MSB;
      b_c = b_c ^ MSB;
    end
    fixed_n = fixed_q;
    gt_n    = gt_q;
    if (!fixed_q && a_c != b_c) begin
      fixed_n = 1'b1;
      gt_n    = (a_c > b_c);
    end
    done = (cnt == '0) || (EARLY && fixed_n);
  end

  // Control FSM, operand capture, decision and result flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      a_q            <= '0;
      b_q            <= '0;
      sgn_q          <= 1'b0;
      fixed_q        <= 1'b0;
      gt_q           <= 1'b0;
      data_resultRDY <= 1'b0;
      isEqual        <= 1'b0;
      isLessThan     <= 1'b0;
      isGreaterThan  <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            a_q     <= data_operandA;
            b_q     <= data_operandB;
            sgn_q   <= signed_mode;
            cnt     <= TOP;
            fixed_q <= 1'b0;
            gt_q    <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          fixed_q <= fixed_n;
          gt_q    <= gt_n;
          if (done) begin
            isEqual        <= !fixed_n;
            isGreaterThan  <= fixed_n && gt_n;
            isLessThan     <= fixed_n && !gt_n;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_comparator.sv
// tb_iter_comparator: randomized and directed checks of iter_comparator
// against a plain-arithmetic reference model.
module tb_iter_comparator;
  localparam int W = 32;
  localparam int C = 4;
  localparam int N = W / C;
`ifdef ITER_COMPARATOR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_start = 1'b0;
  logic         signed_mode = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         busy;
  logic         rdy;
  logic         eq;
  logic         lt;
  logic         gt;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  iter_comparator #(.WIDTH(W), .CHUNK(C)) dut (
    .clock(clock),
    .reset(reset),
    .ctrl_start(ctrl_start),
    .signed_mode(signed_mode),
    .data_operandA(op_a),
    .data_operandB(op_b),
    .busy(busy),
    .data_resultRDY(rdy),
    .isEqual(eq),
    .isLessThan(lt),
    .isGreaterThan(gt)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {eq, lt, gt} from ordinary integer comparison
  function automatic logic [2:0] model_flags(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic s);
    longint va;
    longint vb;
    if (s) begin
      va = longint'($signed(a));
      vb = longint'($signed(b));
    end else begin
      va = longint'({32'd0, a});
      vb = longint'({32'd0, b});
    end
    if (va == vb) return 3'b100;
    if (va < vb) return 3'b010;
    return 3'b001;
  endfunction

  function automatic int model_lat(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    if (!EE || x == '0) return N;
    for (int j = 0; j < N; j++)
      if (((x >> ((N - 1 - j) * C)) & W'((1 << C) - 1)) != '0)
        return j + 1;
    return N;
  endfunction

  // Count edges until the result pulse; lat=99 on timeout
  task automatic wait_rdy(output int lat);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      lat++;
      if (rdy) return;
    end
    lat = 99;
  endtask

  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input string tag);
    int lat;
    logic [2:0] ef;
    @(negedge clock);
    op_a = a;
    op_b = b;
    signed_mode = s;
    ctrl_start = 1'b1;
    @(posedge clock);
    #1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    @(negedge clock);
    ctrl_start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    signed_mode = 1'($urandom);
    if (model_lat(a, b) == 1) begin
      lat = rdy ? 1 : 0;
      if (lat == 0) wait_rdy(lat);
    end else begin
      wait_rdy(lat);
      lat = lat + 0;
    end
    ef = model_flags(a, b, s);
    check({tag, "_lat"}, 64'(lat), 64'(model_lat(a, b)));
    check({tag, "_flags"}, 64'({eq, lt, gt}), 64'(ef));
    check({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    check({tag, "_pulse"}, 64'(rdy), 64'd0);
    check({tag, "_hold"}, 64'({eq, lt, gt}), 64'(ef));
  endtask

  initial begin
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic s0;
    logic s1;
    int lat;
    logic seen;

    #2;
    check("rst_out", 64'({busy, rdy, eq, lt, gt}), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    run_cmp(32'h0000_1234, 32'h0000_1234, 1'b0, "eq_1234");
    run_cmp(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "neg1_s");
    run_cmp(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "neg1_u");
    run_cmp(32'h1000_0005, 32'h1000_0003, 1'b0, "low_gt");
    run_cmp(32'h1200_0000, 32'h1100_0000, 1'b0, "hi_gt");
    run_cmp(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "min_max");
    run_cmp(32'h0000_0000, 32'h0000_0000, 1'b1, "zero_eq");

    for (int i = 0; i < 40; i++) begin
      a0 = $urandom;
      case ($urandom_range(0, 3))
        0: b0 = a0;
        1: b0 = $urandom;
        default: b0 = a0 ^ (32'h1 << $urandom_range(0, 31));
      endcase
      run_cmp(a0, b0, 1'($urandom), "rand");
    end

    // ctrl_start held high, operands churned every cycle, back-to-back
    a0 = $urandom;
    b0 = a0 ^ 32'h0000_0100;
    s0 = 1'b1;
    @(negedge clock);
    op_a = a0;
    op_b = b0;
    signed_mode = s0;
    ctrl_start = 1'b1;
    @(posedge clock);
    #1;
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clock);
      op_a = $urandom;
      op_b = $urandom;
      signed_mode = 1'($urandom);
      @(posedge clock);
      #1;
      lat++;
      seen = rdy;
    end
    if (!seen) lat = 99;
    check("hold_lat", 64'(lat), 64'(model_lat(a0, b0)));
    check("hold_flags", 64'({eq, lt, gt}), 64'(model_flags(a0, b0, s0)));
    a1 = $urandom;
    b1 = $urandom;
    s1 = 1'($urandom);
    @(negedge clock);
    op_a = a1;
    op_b = b1;
    signed_mode = s1;
    @(posedge clock);
    #1;
    check("b2b_busy", 64'(busy), 64'd1);
    @(negedge clock);
    ctrl_start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    if (model_lat(a1, b1) == 1 && rdy) lat = 1;
    else wait_rdy(lat);
    check("b2b_lat", 64'(lat), 64'(model_lat(a1, b1)));
    check("b2b_flags", 64'({eq, lt, gt}), 64'(model_flags(a1, b1, s1)));

    // reset in the middle of an 8-edge compare
    @(negedge clock);
    op_a = 32'h0000_1234;
    op_b = 32'h0000_1234;
    signed_mode = 1'b0;
    ctrl_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_start = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst", 64'({busy, rdy, eq, lt, gt}), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (rdy) seen = 1'b1;
    end
    check("no_pulse", 64'(seen), 64'd0);
    run_cmp(32'd5, 32'd9, 1'b0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
